// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - packs UART RX bytes into words and writes them to instruction memory
//
// Purpose:
//   Collects received bytes little-endian into 32-bit words.
//   Each completed word is written through a req/gnt port at an auto-incrementing word address.
//   Loading stops when a word equal to END_WORD completes on a 4-byte boundary.
//   That marker word is never written.
//   A one-byte hold buffer absorbs a byte that arrives while a write is waiting for its grant.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   en_i                          loader enable (level); low aborts to IDLE
//   rx_dv_i, rx_byte_i            byte strobe and byte from the UART receiver
//   mem_req_o, mem_we_o           write request / write enable, held until mem_gnt_i
//   mem_addr_o, mem_wdata_o       word address and assembled word
//   mem_wmask_o                   4'hF while requesting, else 0
//   mem_gnt_i                     memory grant
//   busy_o, done_o                collecting/writing, end marker seen
//   overrun_o                     sticky: a byte was dropped
//   word_count_o                  words written since load start
//   csum_o                        mod-256 sum of accepted bytes (only with LOADER_CHECKSUM_EN)
//
// Build option:
//   LOADER_CHECKSUM_EN            adds csum_o and its accumulator

module uart_prog_loader #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] END_WORD   = 32'h00000FFF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  rx_dv_i,
  input  logic [7:0]            rx_byte_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_wmask_o,
  input  logic                  mem_gnt_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overrun_o,
  output logic [ADDR_WIDTH:0]   word_count_o
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]            csum_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           word_q, word_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overrun_q, overrun_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [7:0]            hold_byte_q, hold_byte_d;

  logic                  take;
  logic [7:0]            in_byte;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`else
  // Checksum disabled: no accumulator state exists in this build.
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    idx_d        = idx_q;
    word_d       = word_q;
    count_d      = count_q;
    overrun_d    = overrun_q;
    hold_valid_d = hold_valid_q;
    hold_byte_d  = hold_byte_q;
    take         = 1'b0;
    in_byte      = 8'h00;
`ifdef LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (en_i) begin
          state_d      = S_COLLECT;
          addr_d       = '0;
          idx_d        = '0;
          word_d       = '0;
          count_d      = '0;
          overrun_d    = 1'b0;
          hold_valid_d = 1'b0;
          hold_byte_d  = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d       = '0;
`endif
        end
      end

      S_COLLECT: begin
        if (!en_i) begin
          state_d = S_IDLE;
        end else begin
          // The held byte arrived first, so it is consumed before a new strobe;
          // a simultaneous strobe refills the hold slot, keeping order intact.
          if (hold_valid_q) begin
            take         = 1'b1;
            in_byte      = hold_byte_q;
            hold_valid_d = rx_dv_i;
            if (rx_dv_i) begin
              hold_byte_d = rx_byte_i;
            end
          end else if (rx_dv_i) begin
            take    = 1'b1;
            in_byte = rx_byte_i;
          end

          if (take) begin
            word_d[{idx_q, 3'b000} +: 8] = in_byte;
            idx_d = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_d = csum_q + in_byte;
`endif
            if (idx_q == 2'd3) begin
              state_d = (word_d == END_WORD) ? S_DONE : S_WRITE;
            end
          end
        end
      end

      S_WRITE: begin
        if (!en_i) begin
          state_d = S_IDLE;
        end else begin
          if (rx_dv_i) begin
            if (!hold_valid_q) begin
              hold_valid_d = 1'b1;
              hold_byte_d  = rx_byte_i;
            end else begin
              overrun_d = 1'b1;
            end
          end
          if (mem_gnt_i) begin
            addr_d  = addr_q + ADDR_ONE;
            count_d = count_q + COUNT_ONE;
            idx_d   = '0;
            state_d = S_COLLECT;
          end
        end
      end

      S_DONE: begin
        if (!en_i) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      idx_q        <= '0;
      word_q       <= '0;
      count_q      <= '0;
      overrun_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_byte_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      count_q      <= count_d;
      overrun_q    <= overrun_d;
      hold_valid_q <= hold_valid_d;
      hold_byte_q  <= hold_byte_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum_o = csum_q;
`endif

  // Request is decoded straight from the state register so an async reset
  // drops it immediately, without waiting for a clock edge.
  assign mem_req_o    = (state_q == S_WRITE);
  assign mem_we_o     = mem_req_o;
  assign mem_wmask_o  = mem_req_o ? 4'hF : 4'h0;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = word_q;
  assign busy_o       = (state_q == S_COLLECT) || (state_q == S_WRITE);
  assign done_o       = (state_q == S_DONE);
  assign overrun_o    = overrun_q;
  assign word_count_o = count_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - self-checking bench for uart_prog_loader

module tb_uart_prog_loader;

  localparam int AW = 12;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  logic          mem_gnt;
  logic          busy;
  logic          done;
  logic          overrun;
  logic [AW:0]   word_count;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  int checks   = 0;
  int failures = 0;

  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] mon_exp;
  logic [AW-1:0]  exp_addr;

  uart_prog_loader #(
    .ADDR_WIDTH(AW),
    .END_WORD  (32'h00000FFF)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .rx_dv_i     (rx_dv),
    .rx_byte_i   (rx_byte),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_wmask_o (mem_wmask),
    .mem_gnt_i   (mem_gnt),
    .busy_o      (busy),
    .done_o      (done),
    .overrun_o   (overrun),
    .word_count_o(word_count)
`ifdef LOADER_CHECKSUM_EN
    ,
    .csum_o      (csum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every completed write (req & gnt) must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_req === 1'b1 && mem_gnt === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL mem_write unexpected: addr=%0h data=%08h", mem_addr, mem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({mem_we, mem_wmask, mem_addr, mem_wdata} !== {1'b1, 4'hF, mon_exp}) begin
          failures++;
          $display("FAIL mem_write: got we=%b mask=%h addr=%0h data=%08h, want we=1 mask=f addr=%0h data=%08h",
                   mem_we, mem_wmask, mem_addr, mem_wdata, mon_exp[AW+31:32], mon_exp[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    tick();
    rx_dv   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    drive_byte(b);
    tick();
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back({exp_addr, w});
    exp_addr = exp_addr + 1'b1;
  endtask

  task automatic restart();
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    exp_addr = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_wmask, busy, done, overrun} !== 9'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got req=%b we=%b mask=%h busy=%b done=%b ovr=%b, want all 0",
               mem_req, mem_we, mem_wmask, busy, done, overrun);
    end
    checks++;
    if ({mem_addr, mem_wdata, word_count} !== '0) begin
      failures++;
      $display("FAIL reset_data: got addr=%0h data=%08h count=%0d, want 0", mem_addr, mem_wdata, word_count);
    end
  endtask

  task automatic test_basic_write();
    logic [7:0] b[4];
    b = '{8'h78, 8'h56, 8'h34, 8'h12};
    mem_gnt = 1'b1;
    en = 1'b1;
    tick();
    exp_addr = '0;
    push_word(32'h12345678);
    for (int i = 0; i < 3; i++) send_byte(b[i]);
    drive_byte(b[3]);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== '0) begin
      failures++;
      $display("FAIL basic_latency: got req=%b addr=%0h, want req=1 addr=0", mem_req, mem_addr);
    end
    tick();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || mem_wmask !== 4'h0 || mem_addr !== 12'd1 || word_count !== 13'd1) begin
      failures++;
      $display("FAIL basic_after: got req=%b mask=%h addr=%0h count=%0d, want 0 0 1 1",
               mem_req, mem_wmask, mem_addr, word_count);
    end
  endtask

  task automatic test_end_word();
    logic [7:0] b[4];
    b = '{8'hFF, 8'h0F, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) send_byte(b[i]);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || word_count !== 13'd1 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL end_word: got done=%b busy=%b count=%0d req=%b, want 1 0 1 0", done, busy, word_count, mem_req);
    end
    for (int i = 0; i < 4; i++) send_byte(8'hA5);
    checks++;
    if (done !== 1'b1 || word_count !== 13'd1) begin
      failures++;
      $display("FAIL done_ignores_rx: got done=%b count=%0d, want 1 1", done, word_count);
    end
    en = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || word_count !== 13'd1) begin
      failures++;
      $display("FAIL done_to_idle: got done=%b busy=%b count=%0d, want 0 0 1", done, busy, word_count);
    end
  endtask

  task automatic test_stall_overrun();
    logic [7:0] b[4];
    b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    mem_gnt = 1'b0;
    restart();
    push_word(32'hA4A3A2A1);
    for (int i = 0; i < 4; i++) send_byte(b[i]);
    repeat (20) tick();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== '0 || mem_wdata !== 32'hA4A3A2A1) begin
      failures++;
      $display("FAIL stall_hold: got req=%b addr=%0h data=%08h, want 1 0 a4a3a2a1", mem_req, mem_addr, mem_wdata);
    end
    send_byte(8'hB0);
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_early: got %b, want 0", overrun);
    end
    send_byte(8'hB1);
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set: got %b, want 1", overrun);
    end
    mem_gnt = 1'b1;
    tick();
    push_word(32'hC3C2C1B0);
    send_byte(8'hC1);
    send_byte(8'hC2);
    send_byte(8'hC3);
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (overrun !== 1'b1 || word_count !== 13'd2 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL stall_after: got ovr=%b count=%0d pending=%0d, want 1 2 0", overrun, word_count, exp_q.size());
    end
  endtask

  task automatic test_abort();
    logic [7:0] w[12];
    w = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'h11, 8'hFF, 8'h0F, 8'h00, 8'h00, 8'h22, 8'h33, 8'h44};
    send_byte(8'hD1);
    send_byte(8'hD2);
    en = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || word_count !== 13'd2) begin
      failures++;
      $display("FAIL abort_idle: got busy=%b count=%0d, want 0 2", busy, word_count);
    end
    en = 1'b1;
    tick();
    exp_addr = '0;
    push_word(32'hE3E2E1E0);
    push_word(32'h000FFF11);
    push_word(32'h44332200);
    for (int i = 0; i < 12; i++) send_byte(w[i]);
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (word_count !== 13'd3 || busy !== 1'b1 || done !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL abort_restart: got count=%0d busy=%b done=%b pending=%0d, want 3 1 0 0",
               word_count, busy, done, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    mem_gnt = 1'b1;
    restart();
    push_word(32'h03020100);
    push_word(32'h07060504);
    for (int i = 0; i < 8; i++) begin
      rx_dv   = 1'b1;
      rx_byte = 8'(i);
      tick();
    end
    rx_dv = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (word_count !== 13'd2 || overrun !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL back_to_back: got count=%0d ovr=%b pending=%0d, want 2 0 0", word_count, overrun, exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] b[4];
    b = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    mem_gnt = 1'b0;
    restart();
    for (int i = 0; i < 4; i++) send_byte(b[i]);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre: got req=%b, want 1", mem_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_wmask, busy} !== 7'b0) begin
      failures++;
      $display("FAIL areset_async: got req=%b we=%b mask=%h busy=%b, want all 0", mem_req, mem_we, mem_wmask, busy);
    end
    en = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || word_count !== '0 || mem_addr !== '0) begin
      failures++;
      $display("FAIL areset_idle: got busy=%b done=%b count=%0d addr=%0h, want 0", busy, done, word_count, mem_addr);
    end
  endtask

  task automatic test_checksum();
    logic [7:0] b[8];
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'h0F, 8'h00, 8'h00};
    mem_gnt = 1'b1;
    en = 1'b1;
    tick();
    exp_addr = '0;
    push_word(32'h04030201);
    for (int i = 0; i < 8; i++) send_byte(b[i]);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || word_count !== 13'd1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL csum_trace: got done=%b count=%0d pending=%0d, want 1 1 0", done, word_count, exp_q.size());
    end
`ifdef LOADER_CHECKSUM_EN
    checks++;
    if (csum !== 8'h18) begin
      failures++;
      $display("FAIL csum_value: got %02h, want 18", csum);
    end
    send_byte(8'h33);
    checks++;
    if (csum !== 8'h18) begin
      failures++;
      $display("FAIL csum_frozen: got %02h, want 18", csum);
    end
`endif
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    rx_dv    = 1'b0;
    rx_byte  = 8'h00;
    mem_gnt  = 1'b0;
    exp_addr = '0;
    repeat (2) tick();
    test_reset();
    tick();
    rst_n = 1'b1;
    tick();
    test_basic_write();
    test_end_word();
    test_stall_overrun();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_checksum();
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
